// File: rtl/click_sync_tx.sv
// click_sync_tx: synchronous FIFO draining into a 2-phase click-buffer request/ack handshake
module click_sync_tx #(
  parameter int DW    = 2,
  parameter int DEPTH = 4,
  parameter int SYNC  = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_valid,
  input  logic [DW-1:0]            i_data,
  output logic                     o_ready,
  output logic                     o_req,
  output logic [DW-1:0]            o_data,
  input  logic                     i_ack,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_done,
  output logic                     o_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [SYNC-1:0] sync;
  logic            ack_s, push, pop, done_nxt, spur;

  assign ack_s   = sync[SYNC-1];
  assign o_ready = o_count < CW'(DEPTH);
  assign push    = i_valid && o_ready;

  // Handshake decisions: launch from IDLE on matching phases, complete in WAIT on matching phases
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done_nxt  = 1'b0;
    spur      = 1'b0;
    if (state == IDLE) begin
      spur      = ack_s != o_req;
      pop       = !spur && o_count != '0;
      state_nxt = pop ? WAIT : IDLE;
    end else if (ack_s == o_req) begin
      state_nxt = IDLE;
      done_nxt  = 1'b1;
    end
  end

  // Handshake state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Ack synchronizer; only its last stage is looked at
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) sync <= '0;
    else         sync <= {sync[SYNC-2:0], i_ack};
  end

  // Storage array; contents are meaningless until the write pointer passes over them
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      o_count <= o_count + CW'(push) - CW'(pop);
    end
  end

  // Click-side outputs: data and request change together only on a launch
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_data <= '0;
      o_req  <= 1'b0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      if (pop) begin
        o_data <= mem[rd_ptr];
        o_req  <= ~o_req;
      end
      o_done <= done_nxt;
      o_err  <= o_err | spur;
    end
  end
endmodule

// File: tb/tb_click_sync_tx.sv
// tb_click_sync_tx: randomized bench comparing click_sync_tx to a queue-based reference every cycle
module tb_click_sync_tx;
  localparam int DW = 2, DEPTH = 4, SYNC = 2, CW = $clog2(DEPTH) + 1;

  logic clk = 0, rstn = 0, valid = 0;
  logic [DW-1:0] data = '0;
  logic a_auto = 0, a_man = 0;
  logic ack;
  logic ready, req, done, err;
  logic [DW-1:0] odata;
  logic [CW-1:0] count;

  assign ack = a_auto ^ a_man;

  click_sync_tx #(.DW(DW), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .i_data(data), .o_ready(ready),
    .o_req(req), .o_data(odata), .i_ack(ack), .o_count(count), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: FIFO as a queue, handshake as a busy flag, ack seen SYNC edges late
  logic [DW-1:0] q[$];
  logic [DW-1:0] in_log[$], out_log[$];
  logic          req_log[$];
  logic          m_req = 0, m_busy = 0, m_done = 0, m_err = 0;
  logic [DW-1:0] m_data = '0;
  logic [SYNC-1:0] hist = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      m_req <= 0; m_busy <= 0; m_done <= 0; m_err <= 0; m_data <= '0; hist <= '0;
    end else begin
      automatic logic acks = hist[SYNC-1];
      automatic bit can_push = valid && (q.size() < DEPTH);
      automatic bit launch = !m_busy && (q.size() != 0) && (acks == m_req);
      m_done <= m_busy && (acks == m_req);
      if (!m_busy && acks != m_req) m_err <= 1;
      if (launch) begin
        m_data <= q.pop_front();
        m_req  <= !m_req;
        m_busy <= 1;
      end else if (m_busy && acks == m_req) m_busy <= 0;
      if (can_push) begin
        q.push_back(data);
        in_log.push_back(data);
      end
      hist <= {hist[SYNC-2:0], ack};
    end
  end

  // Every-cycle comparison of all outputs against the reference
  always @(negedge clk) begin
    chk("req", req, m_req);
    chk("data", odata, m_data);
    chk("count", count, q.size());
    chk("ready", ready, q.size() < DEPTH);
    chk("done", done, m_done);
    chk("err", err, m_err);
  end

  // Record every launch seen on the click side
  logic prev_req = 0;
  always @(negedge clk) begin
    if (!rstn) prev_req = 0;
    else if (req !== prev_req) begin
      out_log.push_back(odata);
      req_log.push_back(req);
      prev_req = req;
    end
  end

  // Downstream click buffer: answers each request after a random delay
  bit auto_ack = 0, pend = 0;
  int max_dly = 5, dly = 0;
  always @(negedge clk) begin
    if (!auto_ack || !rstn) pend = 0;
    else if (req !== ack) begin
      if (!pend) begin pend = 1; dly = $urandom_range(0, max_dly); end
      if (dly == 0) begin a_auto = ~a_auto; pend = 0; end
      else dly--;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 0;
    auto_ack = 0;
    a_man = a_auto;
    valid = 0;
    in_log.delete(); out_log.delete(); req_log.delete();
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_data", odata, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", ready, 1);
    chk("rst_err", err, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    #2 rstn = 1;
    @(negedge clk);
  endtask

  task automatic drain(string name, int budget);
    int k;
    for (k = 0; k < budget && (q.size() != 0 || m_busy); k++) @(negedge clk);
    chk(name, (q.size() == 0 && !m_busy), 1);
    @(negedge clk);
  endtask

  initial begin : guard
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [DW-1:0] w[5];
    int seen, n, ndone;
    w[0] = 2'b00; w[1] = 2'b01; w[2] = 2'b10; w[3] = 2'b11; w[4] = 2'b01;

    // single word latency and completion
    do_reset();
    valid = 1; data = 2'b10;
    @(negedge clk);
    valid = 0;
    chk("t1_count_after_push", count, 1);
    chk("t1_req_before_launch", req, 0);
    @(negedge clk);
    chk("t1_req_launch", req, 1);
    chk("t1_data_launch", odata, 2'b10);
    chk("t1_count_after_launch", count, 0);
    a_man = ~a_man;
    seen = 0; n = 0; ndone = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (done) begin ndone++; if (!seen) begin seen = 1; n = i; end end
    end
    chk("t1_done_seen", seen, 1);
    chk("t1_done_latency_2to3", (n >= 2 && n <= 3), 1);
    chk("t1_done_one_cycle", ndone, 1);
    chk("t1_err_clear", err, 0);

    // burst to full with ack held, then drain
    do_reset();
    for (int i = 0; i < 5; i++) begin
      valid = 1; data = w[i];
      @(negedge clk);
    end
    valid = 0;
    chk("t2_count_full", count, 4);
    chk("t2_ready_full", ready, 0);
    chk("t2_first_data", odata, 2'b00);
    valid = 1; data = 2'b11;
    @(negedge clk);
    valid = 0;
    chk("t2_sixth_refused", count, 4);
    auto_ack = 1;
    drain("t2_drain_timeout", 200);
    chk("t2_launch_count", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++) begin
      chk("t2_order", out_log[i], w[i]);
      chk("t2_req_alt", req_log[i], (i % 2 == 0));
    end
    chk("t2_err", err, 0);

    // push coinciding with a launch pop at count 2
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      valid = 1; data = DW'(i);
      @(negedge clk);
    end
    valid = 0;
    chk("t3_count_pre", count, 2);
    a_man = ~a_man;
    n = 0;
    while (!done && n < 10) begin @(negedge clk); n++; end
    chk("t3_done_timeout", done, 1);
    chk("t3_count_at_done", count, 2);
    valid = 1; data = 2'b00;
    @(negedge clk);
    valid = 0;
    chk("t3_count_same", count, 2);
    chk("t3_launch_req", req, 0);
    chk("t3_launch_data", odata, 2'b10);
    auto_ack = 1;
    drain("t3_drain_timeout", 200);
    chk("t3_words", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) chk("t3_order", out_log[i], (i + 1) % 4);

    // spurious ack in IDLE, then async reset clears the error
    do_reset();
    a_man = ~a_man;
    seen = 0;
    for (int i = 1; i <= 3; i++) begin @(negedge clk); if (err) seen = 1; end
    chk("t4_err_within_3", seen, 1);
    valid = 1; data = 2'b11;
    @(negedge clk);
    valid = 0;
    repeat (6) @(negedge clk);
    chk("t4_no_launch", req, 0);
    chk("t4_count_held", count, 1);
    chk("t4_err_sticky", err, 1);
    #2 rstn = 0;
    a_man = a_auto;
    #1;
    chk("t4_async_err", err, 0);
    chk("t4_async_count", count, 0);
    @(negedge clk);
    #2 rstn = 1;
    @(negedge clk);

    // async reset in the middle of an open transfer
    do_reset();
    for (int i = 0; i < 3; i++) begin
      valid = 1; data = w[i + 1];
      @(negedge clk);
    end
    valid = 0;
    chk("t5_req_open", req, 1);
    chk("t5_count_open", count, 2);
    @(posedge clk);
    #2 rstn = 0;
    a_man = a_auto;
    #1;
    chk("t5_async_req", req, 0);
    chk("t5_async_count", count, 0);
    chk("t5_async_err", err, 0);
    chk("t5_async_ready", ready, 1);
    chk("t5_async_data", odata, 0);
    @(negedge clk);
    #2 rstn = 1;
    @(negedge clk);

    // randomized streaming with random ack delay, then with immediate ack
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      max_dly = ph == 0 ? 5 : 0;
      auto_ack = 1;
      for (int c = 0; c < 300; c++) begin
        valid = ph == 0 ? ($urandom_range(0, 2) != 0) : 1'b1;
        data = DW'($urandom);
        @(negedge clk);
      end
      valid = 0;
      drain("t6_drain_timeout", 400);
      chk("t6_enough_words", in_log.size() >= 12, 1);
      chk("t6_word_count", out_log.size(), in_log.size());
      for (int i = 0; i < out_log.size() && i < in_log.size(); i++) chk("t6_order", out_log[i], in_log[i]);
      chk("t6_err", err, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
